// File: rtl/display_pkg.sv
// Shared digit-code constants and the per-digit leading-zero blanking step
// used by the display mode/scan block.
package display_pkg;

    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] BLANK_CODE = 4'd10;

    typedef struct packed {
        logic              run;
        logic [CODE_W-1:0] code;
    } lz_t;

    // One step of the blanking run: a zero inside an active run goes dark and the
    // run continues; anything else passes unchanged and ends the run.
    function automatic lz_t lz_blank(input logic [CODE_W-1:0] code, input logic run);
        lz_t res;
        if (run && (code == 4'd0)) begin
            res.run  = 1'b1;
            res.code = BLANK_CODE;
        end else begin
            res.run  = 1'b0;
            res.code = code;
        end
        return res;
    endfunction

endpackage

// File: rtl/display_scan_ctrl.sv
// Digit scan index (modulo DIGITS, stepped by iTick) and the blink
// half-period counter with its phase flag.
module display_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int BLINK_TICKS = 250,
    localparam int IDX_W      = $clog2(DIGITS),
    localparam int CNT_W      = $clog2(BLINK_TICKS + 1)
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iTick,
    input  logic             iBlinkEn,
    output logic [IDX_W-1:0] ovIdx,
    output logic             oPhase
);

    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // Scan index advance with explicit wrap so non-power-of-two digit counts stay legal.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_idx <= '0;
        end else if (iTick) begin
            if (r_idx == IDX_W'(DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    // Blink counter: parked at zero with the phase lit while blinking is disabled.
    always_ff @(posedge iClk) begin
        if (iReset || !iBlinkEn) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (iTick) begin
            if (r_cnt == CNT_W'(BLINK_TICKS - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt   <= r_cnt;
            r_phase <= r_phase;
        end
    end

    assign ovIdx  = r_idx;
    assign oPhase = r_phase;

endmodule

// File: rtl/display_mode_scan.sv
// Per-mode digit source selection, leading-zero blanking, digit latch and
// registered multiplexed scan outputs for the seven-segment decoder.
module display_mode_scan
    import display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int NUM_SRC     = 3,
    parameter int MODE_W      = 2,
    parameter int BLINK_TICKS = 250
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iCE,
    input  logic [MODE_W-1:0]            ivMode,
    input  logic [NUM_SRC*DIGITS*4-1:0]  ivSrc,
    input  logic                         iBlankLZ,
    input  logic                         iBlinkEn,
    input  logic                         iTick,
    output logic [DIGITS*4-1:0]          ovDigits,
    output logic [DIGITS-1:0]            ovAnode,
    output logic [3:0]                   ovCode,
    output logic                         oBlinkPhase
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int VEC_W = DIGITS * CODE_W;

    logic [IDX_W-1:0]  w_idx;
    logic              w_phase;
    logic [VEC_W-1:0]  w_sel;
    logic [VEC_W-1:0]  w_lz;
    logic [VEC_W-1:0]  r_digits;
    logic [DIGITS-1:0] r_anode;
    logic [CODE_W-1:0] r_code;

    display_scan_ctrl #(
        .DIGITS      (DIGITS),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_scan_ctrl (
        .iClk     (iClk),
        .iReset   (iReset),
        .iTick    (iTick),
        .iBlinkEn (iBlinkEn),
        .ovIdx    (w_idx),
        .oPhase   (w_phase)
    );

    // Source mux; unmapped modes show a fully dark display.
    always_comb begin
        w_sel = {DIGITS{BLANK_CODE}};
        for (int s = 0; s < NUM_SRC; s++) begin
            if ({1'b0, ivMode} == (MODE_W + 1)'(s)) begin
                w_sel = ivSrc[s*VEC_W +: VEC_W];
            end else begin
                w_sel = w_sel;
            end
        end
    end

    // Leading-zero blanking from the leftmost digit down; digit 0 always shows.
    always_comb begin
        lz_t  v_step;
        logic v_run;
        w_lz   = w_sel;
        v_run  = iBlankLZ;
        v_step = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            v_step = lz_blank(w_sel[d*CODE_W +: CODE_W], v_run);
            w_lz[d*CODE_W +: CODE_W] = v_step.code;
            v_run  = v_step.run;
        end
    end

    // Digit latch and scan output registers, driven from pre-edge index, digits and phase.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_digits <= {DIGITS{BLANK_CODE}};
            r_anode  <= '1;
            r_code   <= BLANK_CODE;
        end else begin
            if (iCE) begin
                r_digits <= w_lz;
            end else begin
                r_digits <= r_digits;
            end
            if (w_phase) begin
                r_anode <= '1;
                r_code  <= BLANK_CODE;
            end else begin
                r_anode <= ~(DIGITS'(1) << w_idx);
                r_code  <= r_digits[w_idx*CODE_W +: CODE_W];
            end
        end
    end

    assign ovDigits    = r_digits;
    assign ovAnode     = r_anode;
    assign ovCode      = r_code;
    assign oBlinkPhase = w_phase;

endmodule
